// File: rtl/regfile_dump.sv
// regfile_dump: halts the core, walks a register range through a spare read port
// and streams each value out over a valid/ready interface.
module regfile_dump #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 5,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              cpu_halt,
  input  logic              cpu_halted,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, HALT_WAIT, READ, CAPT, SEND, DONE} state_t;
  state_t state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      cpu_halt   <= 1'b0;
      rf_rd_addr <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= HALT_WAIT;
          cpu_halt <= 1'b1;
          busy     <= 1'b1;
        end
        HALT_WAIT: if (cpu_halted) begin
          rf_rd_addr <= ADDR_W'(FIRST_REG);
          state      <= READ;
        end
        READ: state <= CAPT;
        CAPT: begin
          out_data  <= rf_rd_data;
          out_index <= rf_rd_addr;
          out_last  <= rf_rd_addr == ADDR_W'(LAST_REG);
          out_valid <= 1'b1;
          state     <= SEND;
        end
        // stopping on out_last keeps the address from wrapping at the top register
        SEND: if (out_ready) begin
          out_valid <= 1'b0;
          if (out_last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            rf_rd_addr <= rf_rd_addr + ADDR_W'(1);
            state      <= READ;
          end
        end
        DONE: begin
          done     <= 1'b0;
          cpu_halt <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
